// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {HOLD, IDLE, WRITE, FILL} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  localparam int unsigned DEF_WORDS_PER_BLOCK = 8;
  localparam int unsigned WORD_IDX_W          = $clog2(DEF_WORDS_PER_BLOCK);
  localparam int unsigned OFFSET_W            = WORD_IDX_W + 1;

  // Width of the post-reset holdoff counter; at least one bit.
  function automatic int unsigned hold_w(input int unsigned lat);
    return (lat < 2) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational 3-request picker: store first, then D/I fill.
// MEM_ARB_RR_EN: D/I fills alternate via a last-served flag; otherwise D beats I.
module mem_arb_pick
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic clk,
  input  logic rst_n,
  input  logic grant_en,
`endif
  input  logic wr_req,
  input  logic d_req,
  input  logic i_req,
  output logic pick_wr,
  output logic pick_d,
  output logic pick_i
);

  logic d_first;

`ifdef MEM_ARB_RR_EN
  owner_t last_q;

  assign d_first = (last_q == OWN_I);

  // Remember who got the last fill; reset value lets D win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= OWN_I;
    end else if (grant_en) begin
      last_q <= pick_d ? OWN_D : OWN_I;
    end
  end
`else
  assign d_first = 1'b1;
`endif

  // Store has absolute priority; fills resolve the D/I tie with d_first.
  always_comb begin
    pick_wr = wr_req;
    pick_d  = 1'b0;
    pick_i  = 1'b0;
    if (!wr_req) begin
      if (d_req && (d_first || !i_req)) begin
        pick_d = 1'b1;
      end else if (i_req) begin
        pick_i = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Main-memory port arbiter: I/D block fills and D write-through stores.
// Define MEM_ARB_RR_EN for round-robin D/I fill arbitration.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter int unsigned MEM_LATENCY     = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_fill_req,
  input  logic [ADDR_WIDTH-1:0]              i_fill_addr,
  input  logic                               d_fill_req,
  input  logic [ADDR_WIDTH-1:0]              d_fill_addr,
  input  logic                               d_wr_req,
  input  logic [ADDR_WIDTH-1:0]              d_wr_addr,
  input  logic [15:0]                        d_wr_data,
  output logic                               d_wr_ack,
  output logic [15:0]                        fill_data,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
  output logic                               i_fill_valid,
  output logic                               d_fill_valid,
  output logic                               i_fill_done,
  output logic                               d_fill_done,
  output logic                               busy,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  output logic [15:0]                        mem_data_in,
  output logic                               mem_enable,
  output logic                               mem_wr,
  input  logic [15:0]                        mem_data_out,
  input  logic                               mem_data_valid
);

  localparam int unsigned WIW    = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned OFW    = WIW + 1;
  localparam int unsigned HOLD_W = hold_w(MEM_LATENCY);

  state_t                   state_q, state_d;
  owner_t                   owner_q;
  logic [ADDR_WIDTH-OFW-1:0] blk_q;
  logic [OFW-1:0]           iss_q, ret_q;
  logic [HOLD_W-1:0]        hold_q;

  logic                     pick_wr, pick_d, pick_i;
  logic                     fill_grant, issuing, ret_ok, ret_last;
  logic [ADDR_WIDTH-1:0]    grant_addr;
  logic                     unused_bits;

  assign fill_grant  = (state_q == IDLE) && (pick_d || pick_i);
  assign grant_addr  = pick_d ? d_fill_addr : i_fill_addr;
  // Counters carry one extra bit so "all WPB done" is just the top bit.
  assign issuing     = (state_q == FILL) && !iss_q[WIW];
  assign ret_ok      = (state_q == FILL) && mem_data_valid && !ret_q[WIW];
  assign ret_last    = ret_ok && (ret_q[WIW-1:0] == WIW'(WORDS_PER_BLOCK - 1));
  assign unused_bits = ^{d_wr_addr[0], grant_addr[OFW-1:0]};

  mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .clk      (clk),
    .rst_n    (rst_n),
    .grant_en (fill_grant),
`endif
    .wr_req   (d_wr_req),
    .d_req    (d_fill_req),
    .i_req    (i_fill_req),
    .pick_wr  (pick_wr),
    .pick_d   (pick_d),
    .pick_i   (pick_i)
  );

  // State, holdoff, latched block/owner and issue/return counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HOLD;
      hold_q  <= HOLD_W'(MEM_LATENCY);
      owner_q <= OWN_I;
      blk_q   <= '0;
      iss_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == HOLD && hold_q != '0) begin
        hold_q <= hold_q - HOLD_W'(1);
      end
      if (fill_grant) begin
        blk_q   <= grant_addr[ADDR_WIDTH-1:OFW];
        owner_q <= pick_d ? OWN_D : OWN_I;
        iss_q   <= '0;
        ret_q   <= '0;
      end else begin
        if (issuing) iss_q <= iss_q + OFW'(1);
        if (ret_ok)  ret_q <= ret_q + OFW'(1);
      end
    end
  end

  // Next state and all port outputs; idle defaults first.
  always_comb begin
    state_d      = state_q;
    d_wr_ack     = 1'b0;
    fill_data    = '0;
    fill_word    = '0;
    i_fill_valid = 1'b0;
    d_fill_valid = 1'b0;
    i_fill_done  = 1'b0;
    d_fill_done  = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    busy         = rst_n && ((state_q != IDLE) || (hold_q != '0));
    case (state_q)
      HOLD: begin
        if (hold_q <= HOLD_W'(1)) state_d = IDLE;
      end
      IDLE: begin
        if (pick_wr)                state_d = WRITE;
        else if (pick_d || pick_i)  state_d = FILL;
      end
      WRITE: begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = {d_wr_addr[ADDR_WIDTH-1:1], 1'b0};
        mem_data_in = d_wr_data;
        d_wr_ack    = 1'b1;
        state_d     = IDLE;
      end
      FILL: begin
        if (issuing) begin
          mem_enable = 1'b1;
          mem_addr   = {blk_q, iss_q[WIW-1:0], 1'b0};
        end
        if (ret_ok) begin
          fill_data    = mem_data_out;
          fill_word    = ret_q[WIW-1:0];
          i_fill_valid = (owner_q == OWN_I);
          d_fill_valid = (owner_q == OWN_D);
        end
        if (ret_last) begin
          i_fill_done = (owner_q == OWN_I);
          d_fill_done = (owner_q == OWN_D);
          state_d     = IDLE;
        end
      end
      default: state_d = HOLD;
    endcase
  end

endmodule
